cwe1280_access_arbiter: RTL and testbench



---
 rtl/cwe1280_pkg.sv | 14 +
 rtl/cwe1280_access_arbiter_if.sv | 25 ++
 rtl/cwe1280_rr_pick.sv | 35 +++
 rtl/cwe1280_access_arbiter.sv | 110 +++++++++++
 tb/tb_cwe1280_access_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/cwe1280_pkg.sv
// rtl/cwe1280_pkg.sv - shared types and constants for the protected-register access arbiter
package cwe1280_pkg;

   typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

   localparam logic [2:0] DEF_AUTH_ID  = 3'h4;
   localparam int         DEF_MAX_DENY = 3;

   // Deny counter must be able to hold MAX_DENY itself.
   function automatic int deny_cnt_w(input int max_deny);
      return $clog2(max_deny + 1);
   endfunction

endpackage

// File: rtl/cwe1280_access_arbiter_if.sv
// rtl/cwe1280_access_arbiter_if.sv - requester-side bus of the access arbiter
interface cwe1280_access_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int IDW  = 3
);
   logic [NREQ-1:0]     req;
   logic [NREQ*IDW-1:0] usr_id;
   logic [NREQ*DW-1:0]  data_in;
   logic [NREQ-1:0]     ack;
   logic [NREQ-1:0]     denied;
   logic [NREQ-1:0]     locked;
   logic [DW-1:0]       data_out;
   logic                busy;

   modport master (
      output req, usr_id, data_in,
      input  ack, denied, locked, data_out, busy
   );

   modport slave (
      input  req, usr_id, data_in,
      output ack, denied, locked, data_out, busy
   );
endinterface

// File: rtl/cwe1280_rr_pick.sv
// rtl/cwe1280_rr_pick.sv - combinational round-robin picker (rotate, priority encode, un-rotate)
module cwe1280_rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [PW-1:0]   ptr,
   output logic            valid,
   output logic [PW-1:0]   idx
);

   logic [NREQ-1:0] rot;
   int              off;

   always_comb begin
      rot = '0;
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = eligible[(i + int'(ptr)) % NREQ];
      end
   end

   // Descending scan so the lowest set bit of the rotated vector wins.
   always_comb begin
      off = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) off = i;
      end
   end

   always_comb begin
      valid = |eligible;
      idx   = PW'((off + int'(ptr)) % NREQ);
   end

endmodule

// File: rtl/cwe1280_access_arbiter.sv
// rtl/cwe1280_access_arbiter.sv - round-robin, ID-checked writer of one protected register
module cwe1280_access_arbiter
   import cwe1280_pkg::*;
#(
   parameter int             NREQ     = 4,
   parameter int             DW       = 8,
   parameter int             IDW      = 3,
   parameter logic [IDW-1:0] AUTH_ID  = IDW'(DEF_AUTH_ID),
   parameter int             MAX_DENY = DEF_MAX_DENY
) (
   input  logic                   clk,
   input  logic                   rst_n,
   cwe1280_access_arbiter_if.slave bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = deny_cnt_w(MAX_DENY);
   localparam logic [CW-1:0] MAX_DENY_C = CW'(MAX_DENY);

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, idx_q, pick_idx;
   logic            pick_valid;
   logic [IDW-1:0]  id_q;
   logic [DW-1:0]   wdata_q, data_out_q;
   logic [NREQ-1:0] ack_q, denied_q, locked_q, eligible;
   logic [CW-1:0]   deny_cnt [NREQ];
   logic [CW-1:0]   cnt_inc;
   logic            busy_c;

   assign eligible = bus.req & ~locked_q;

   cwe1280_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .eligible (eligible),
      .ptr      (ptr),
      .valid    (pick_valid),
      .idx      (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = CHECK;
         CHECK:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_c = (state != IDLE);
   end

   always_comb begin
      cnt_inc = (deny_cnt[idx_q] == {CW{1'b1}}) ? deny_cnt[idx_q] : deny_cnt[idx_q] + CW'(1);
   end

   // ID and data are captured together at grant; CHECK only ever looks at the captured copy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr        <= '0;
         idx_q      <= '0;
         id_q       <= '0;
         wdata_q    <= '0;
         data_out_q <= '0;
         ack_q      <= '0;
         denied_q   <= '0;
         locked_q   <= '0;
         for (int i = 0; i < NREQ; i++) deny_cnt[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  idx_q   <= pick_idx;
                  id_q    <= bus.usr_id[int'(pick_idx)*IDW +: IDW];
                  wdata_q <= bus.data_in[int'(pick_idx)*DW +: DW];
               end
            end
            CHECK: begin
               if (id_q == AUTH_ID) begin
                  data_out_q      <= wdata_q;
                  ack_q[idx_q]    <= 1'b1;
                  deny_cnt[idx_q] <= '0;
               end else begin
                  denied_q[idx_q] <= 1'b1;
                  deny_cnt[idx_q] <= cnt_inc;
                  if (cnt_inc == MAX_DENY_C) locked_q[idx_q] <= 1'b1;
               end
               ptr <= (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
            end
            RESP: begin
               ack_q    <= '0;
               denied_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.ack      = ack_q;
   assign bus.denied   = denied_q;
   assign bus.locked   = locked_q;
   assign bus.data_out = data_out_q;
   assign bus.busy     = busy_c;

endmodule

// File: tb/tb_cwe1280_access_arbiter.sv
// tb/tb_cwe1280_access_arbiter.sv - randomized, model-checked bench for the access arbiter
module tb_cwe1280_access_arbiter;

   localparam int NREQ     = 4;
   localparam int DW       = 8;
   localparam int IDW      = 3;
   localparam int AUTH     = 4;
   localparam int MAX_DENY = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   cwe1280_access_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

   cwe1280_access_arbiter #(
      .NREQ(NREQ), .DW(DW), .IDW(IDW), .AUTH_ID(3'h4), .MAX_DENY(MAX_DENY)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Transaction-level reference: a grant opens a 2-cycle window, the response shows in the second.
   int              m_ptr, m_timer, m_idx, m_id, m_cdata, m_data;
   int              m_cnt [NREQ];
   logic [NREQ-1:0] m_ack, m_den, m_lock;

   task automatic model_step();
      if (!rst_n) begin
         m_ptr = 0; m_timer = 0; m_data = 0;
         m_ack = '0; m_den = '0; m_lock = '0;
         for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end else if (m_timer == 2) begin
         if (m_id == AUTH) begin
            m_data = m_cdata;
            m_ack[m_idx] = 1'b1;
            m_cnt[m_idx] = 0;
         end else begin
            m_den[m_idx] = 1'b1;
            m_cnt[m_idx] = m_cnt[m_idx] + 1;
            if (m_cnt[m_idx] == MAX_DENY) m_lock[m_idx] = 1'b1;
         end
         m_ptr   = (m_idx + 1) % NREQ;
         m_timer = 1;
      end else if (m_timer == 1) begin
         m_ack = '0; m_den = '0; m_timer = 0;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (m_timer == 0 && bus.req[j] && !m_lock[j]) begin
               m_idx   = j;
               m_id    = int'(bus.usr_id[j*IDW +: IDW]);
               m_cdata = int'(bus.data_in[j*DW +: DW]);
               m_timer = 2;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      check("ack",      32'(bus.ack),      32'(m_ack));
      check("denied",   32'(bus.denied),   32'(m_den));
      check("locked",   32'(bus.locked),   32'(m_lock));
      check("data_out", 32'(bus.data_out), 32'(m_data));
      check("busy",     32'(bus.busy),     32'(m_timer != 0));
      check("one_resp", 32'($countones(bus.ack | bus.denied) <= 1), 32'(1));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic set_port(input int p, input logic r, input int id, input int d);
      bus.req[p]                 = r;
      bus.usr_id[p*IDW +: IDW]   = IDW'(id);
      bus.data_in[p*DW +: DW]    = DW'(d);
   endtask

   task automatic txn_expect(input string name, input logic [NREQ-1:0] ack_e,
                             input logic [NREQ-1:0] den_e, input int dout_e);
      check({name, "_ack"},  32'(bus.ack),      32'(ack_e));
      check({name, "_den"},  32'(bus.denied),   32'(den_e));
      check({name, "_dout"}, 32'(bus.data_out), 32'(dout_e));
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.req     = '1;
      bus.usr_id  = '0;
      bus.data_in = '0;
      @(posedge clk); model_step();
      @(posedge clk); model_step();
      @(negedge clk); compare();
      check("rst_busy",   32'(bus.busy),     32'(0));
      check("rst_locked", 32'(bus.locked),   32'(0));
      check("rst_dout",   32'(bus.data_out), 32'(0));
      rst_n   = 1'b1;
      bus.req = '0;

      // Authorised write from port 0
      set_port(0, 1'b1, 4, 'hA5);
      cycle();
      check("auth_busy1", 32'(bus.busy), 32'(1));
      cycle();
      check("auth_busy2", 32'(bus.busy), 32'(1));
      txn_expect("auth", 4'b0001, 4'b0000, 'hA5);
      bus.req[0] = 1'b0;
      cycle();
      check("auth_busy3", 32'(bus.busy), 32'(0));
      check("auth_pulse", 32'(bus.ack),  32'(0));

      // Captured ID is bad; live ID becomes good during CHECK
      set_port(1, 1'b1, 3, 'h5A);
      cycle();
      bus.usr_id[1*IDW +: IDW] = 3'd4;
      cycle();
      txn_expect("stale", 4'b0000, 4'b0010, 'hA5);
      bus.req[1] = 1'b0;
      cycle();

      // Round robin from ptr=2
      set_port(0, 1'b1, 4, 'h11);
      set_port(2, 1'b1, 4, 'h22);
      cycle(); cycle();
      txn_expect("rr_first", 4'b0100, 4'b0000, 'h22);
      bus.req[2] = 1'b0;
      cycle(); cycle(); cycle();
      txn_expect("rr_second", 4'b0001, 4'b0000, 'h11);
      bus.req[0] = 1'b0;
      cycle();

      // Lockout of port 3
      for (int n = 0; n < 3; n++) begin
         set_port(3, 1'b1, 1, 'h30 + n);
         cycle(); cycle();
         txn_expect("lock_deny", 4'b0000, 4'b1000, 'h11);
         bus.req[3] = 1'b0;
         cycle();
      end
      check("lock_flag", 32'(bus.locked), 32'(4'b1000));
      bus.req[3] = 1'b1;
      for (int n = 0; n < 10; n++) begin
         cycle();
         check("lock_idle", 32'(bus.busy | (|bus.ack) | (|bus.denied)), 32'(0));
      end
      set_port(0, 1'b1, 4, 'h66);
      cycle(); cycle();
      txn_expect("after_lock", 4'b0001, 4'b0000, 'h66);
      bus.req = '0;
      cycle();

      // Reset while CHECK holds an authorised request
      set_port(0, 1'b1, 4, 'h77);
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      bus.req = '0;
      txn_expect("mid_rst", 4'b0000, 4'b0000, 0);
      check("mid_rst_lock", 32'(bus.locked), 32'(0));
      check("mid_rst_busy", 32'(bus.busy),   32'(0));

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(299) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] && (m_ack[i] || m_den[i])) begin
               bus.req[i] = 1'b0;
            end else if (!bus.req[i] && $urandom_range(3) == 0) begin
               int good;
               good = (i == 3) ? ($urandom_range(4) == 0) : ($urandom_range(9) < 7);
               set_port(i, 1'b1, good ? AUTH : ($urandom_range(6) + (($urandom_range(6)) >= 4 ? 1 : 0)) % 8 == AUTH ? 0 : $urandom_range(3), $urandom_range(255));
            end else if (bus.req[i] && $urandom_range(15) == 0) begin
               bus.req[i] = 1'b0;
            end
            if ($urandom_range(7) == 0) bus.usr_id[i*IDW +: IDW] = IDW'($urandom_range(7));
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
